// File: rtl/midi_rx_parser.sv
// MIDI 8N1 receiver and channel-voice message parser.
// Build option: define MIDI_RX_REALTIME_EN to add rt_valid/rt_byte ports.
`timescale 1ns/1ps

module midi_rx_parser #(
  parameter int CLKS_PER_BIT = 320
) (
  input  logic       SYSCLK,
  input  logic       NSYSRESET,
  input  logic       MIDI_RX,
  output logic       msg_valid,
  output logic [2:0] msg_type,
  output logic [3:0] msg_chan,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       frame_err
`ifdef MIDI_RX_REALTIME_EN
  ,
  output logic       rt_valid,
  output logic [7:0] rt_byte
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_st_e;

  typedef enum logic [1:0] {
    P_STATUS,
    P_D1,
    P_D2
  } p_st_e;

  // ---------------- synchroniser ----------------
  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rx_s;
  logic fall_d;

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= MIDI_RX;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s   = sync2_q;
  assign fall_d = prev_q & ~rx_s;

  // ---------------- receiver ----------------
  rx_st_e        rx_st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shr_q;
  logic          brk_q;
  logic          stb_q;
  logic [7:0]    byte_q;
  logic          ferr_q;

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      rx_st_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
      brk_q   <= 1'b0;
      stb_q   <= 1'b0;
      byte_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      stb_q  <= 1'b0;
      ferr_q <= 1'b0;
      unique case (rx_st_q)
        RX_IDLE: begin
          if (fall_d) begin
            rx_st_q <= RX_START;
            cnt_q   <= HALF;
          end
        end
        RX_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (rx_s) begin
            rx_st_q <= RX_IDLE;
          end else begin
            rx_st_q <= RX_DATA;
            cnt_q   <= FULL;
            bit_q   <= '0;
          end
        end
        RX_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shr_q <= {rx_s, shr_q[7:1]};
            cnt_q <= FULL;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) rx_st_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          // After a bad stop bit, hold here until the line idles high.
          if (brk_q) begin
            if (rx_s) begin
              brk_q   <= 1'b0;
              rx_st_q <= RX_IDLE;
            end
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (rx_s) begin
            stb_q   <= 1'b1;
            byte_q  <= shr_q;
            rx_st_q <= RX_IDLE;
          end else begin
            ferr_q <= 1'b1;
            brk_q  <= 1'b1;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  assign frame_err = ferr_q;

  // ---------------- parser ----------------
  logic is_stat;
  logic is_sys;
  logic is_rt;
  logic is_data;
  logic take_d1;
  logic short_msg;

  p_st_e      ps_q;
  logic [2:0] rs_type_q;
  logic [3:0] rs_chan_q;
  logic       rs_valid_q;
  logic [6:0] d1_q;
  logic       mv_q;
  logic [2:0] mt_q;
  logic [3:0] mc_q;
  logic [6:0] md1_q;
  logic [6:0] md2_q;
  logic       rtv_q;
  logic [7:0] rtb_q;

  assign is_data   = ~byte_q[7];
  assign is_stat   = byte_q[7] & (byte_q[6:4] != 3'b111);
  assign is_sys    = byte_q[7:3] == 5'b11110;
  assign is_rt     = byte_q[7:3] == 5'b11111;
  assign take_d1   = (ps_q == P_D1) | ((ps_q == P_STATUS) & rs_valid_q);
  assign short_msg = (rs_type_q == 3'd4) | (rs_type_q == 3'd5);

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      ps_q       <= P_STATUS;
      rs_type_q  <= '0;
      rs_chan_q  <= '0;
      rs_valid_q <= 1'b0;
      d1_q       <= '0;
      mv_q       <= 1'b0;
      mt_q       <= '0;
      mc_q       <= '0;
      md1_q      <= '0;
      md2_q      <= '0;
      rtv_q      <= 1'b0;
      rtb_q      <= '0;
    end else begin
      mv_q  <= 1'b0;
      rtv_q <= 1'b0;
      if (ferr_q) begin
        ps_q       <= P_STATUS;
        rs_valid_q <= 1'b0;
      end else if (stb_q) begin
        unique case (1'b1)
          is_stat: begin
            rs_type_q  <= byte_q[6:4];
            rs_chan_q  <= byte_q[3:0];
            rs_valid_q <= 1'b1;
            ps_q       <= P_D1;
          end
          is_sys: begin
            rs_valid_q <= 1'b0;
            ps_q       <= P_STATUS;
          end
          is_rt: begin
            rtv_q <= 1'b1;
            rtb_q <= byte_q;
          end
          is_data: begin
            if (ps_q == P_D2) begin
              mv_q  <= 1'b1;
              // Note on with zero velocity is reported as note off.
              mt_q  <= (rs_type_q == 3'd1 && byte_q[6:0] == 7'd0)
                       ? 3'd0 : rs_type_q;
              mc_q  <= rs_chan_q;
              md1_q <= d1_q;
              md2_q <= byte_q[6:0];
              ps_q  <= P_D1;
            end else if (take_d1) begin
              d1_q <= byte_q[6:0];
              if (short_msg) begin
                mv_q  <= 1'b1;
                mt_q  <= rs_type_q;
                mc_q  <= rs_chan_q;
                md1_q <= byte_q[6:0];
                md2_q <= 7'd0;
                ps_q  <= P_D1;
              end else begin
                ps_q <= P_D2;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign msg_valid = mv_q;
  assign msg_type  = mt_q;
  assign msg_chan  = mc_q;
  assign msg_data1 = md1_q;
  assign msg_data2 = md2_q;

`ifdef MIDI_RX_REALTIME_EN
  assign rt_valid = rtv_q;
  assign rt_byte  = rtb_q;
`else
  logic rt_unused;
  assign rt_unused = rtv_q ^ (^rtb_q);
`endif

endmodule
